// File: rtl/div_sequencer.sv
// div_sequencer: front-end controller for the shared unsigned iterative divider.
// It serves RV M-extension DIV/DIVU/REM/REMU requests one at a time.
// It resolves divide-by-zero and signed overflow without the divider, hands
// operand magnitudes to the divider, and sign-corrects the result. The result
// is held until the pipeline takes it.
// Optional feature: define DIV_RESULT_REUSE_EN to keep a one-entry result
// cache that answers repeated operand pairs without using the divider.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            div_start,
  input  logic            div_ready,
  input  logic            div_valid,
  input  logic            div_error,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | operands latched, waiting for div_ready to pulse start
  // WAIT  | divider busy, waiting for div_valid
  // RESP  | result held on resp_data until resp_ready
  // DRAIN | killed while divider busy, discard its next result
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] rs1_l;

  logic            accept;
  logic            is_signed_in;
  logic [XLEN-1:0] mag1_in;
  logic [XLEN-1:0] mag2_in;
  logic            div0_in;
  logic            ovf_in;
  logic            hit;
  logic [XLEN-1:0] hit_q;
  logic [XLEN-1:0] hit_r;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

`ifdef DIV_RESULT_REUSE_EN
  logic            c_valid;
  logic            c_signed;
  logic [XLEN-1:0] c_rs1;
  logic [XLEN-1:0] c_rs2;
  logic [XLEN-1:0] c_quot;
  logic [XLEN-1:0] c_rem;
  logic            signed_l;
  logic [XLEN-1:0] rs2_l;
`endif

  assign req_ready  = (state == S_IDLE) && !kill;
  assign accept     = req_valid && req_ready;
  assign div_start  = (state == S_ISSUE) && div_ready && !kill;
  assign resp_valid = (state == S_RESP);

  // Decode the incoming request: magnitudes and the two divider-free cases.
  always_comb begin
    is_signed_in = !req_op[0];
    mag1_in      = (is_signed_in && req_rs1[XLEN-1]) ? -req_rs1 : req_rs1;
    mag2_in      = (is_signed_in && req_rs2[XLEN-1]) ? -req_rs2 : req_rs2;
    div0_in      = (req_rs2 == '0);
    ovf_in       = is_signed_in && (req_rs1 == INT_MIN) && (req_rs2 == ONES);
  end

  // Cache lookup; without the reuse feature nothing ever hits.
  always_comb begin
`ifdef DIV_RESULT_REUSE_EN
    hit   = c_valid && (c_signed == is_signed_in) && (c_rs1 == req_rs1) && (c_rs2 == req_rs2);
    hit_q = c_quot;
    hit_r = c_rem;
`else
    hit   = 1'b0;
    hit_q = '0;
    hit_r = '0;
`endif
  end

  // Sign-correct the divider result; a divider error falls back to divide-by-zero values.
  always_comb begin
    q_fix = neg_q ? -div_quotient  : div_quotient;
    r_fix = neg_r ? -div_remainder : div_remainder;
    if (div_error) begin
      q_fix = ONES;
      r_fix = rs1_l;
    end
  end

  // Main sequencer: request latch, divider handshake, result hold and kill handling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      op_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      rs1_l        <= '0;
      resp_data    <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
`ifdef DIV_RESULT_REUSE_EN
      c_valid      <= 1'b0;
      c_signed     <= 1'b0;
      c_rs1        <= '0;
      c_rs2        <= '0;
      c_quot       <= '0;
      c_rem        <= '0;
      signed_l     <= 1'b0;
      rs2_l        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_rem       <= req_op[1];
            neg_q        <= is_signed_in && (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]);
            neg_r        <= is_signed_in && req_rs1[XLEN-1];
            rs1_l        <= req_rs1;
            div_dividend <= mag1_in;
            div_divisor  <= mag2_in;
`ifdef DIV_RESULT_REUSE_EN
            signed_l     <= is_signed_in;
            rs2_l        <= req_rs2;
`endif
            if (div0_in) begin
              resp_data <= req_op[1] ? req_rs1 : ONES;
              state     <= S_RESP;
            end else if (ovf_in) begin
              resp_data <= req_op[1] ? '0 : req_rs1;
              state     <= S_RESP;
            end else if (hit) begin
              resp_data <= req_op[1] ? hit_r : hit_q;
              state     <= S_RESP;
            end else begin
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (kill)           state <= S_IDLE;
          else if (div_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_valid) begin
            if (kill) begin
              state <= S_IDLE;
            end else begin
              resp_data <= op_rem ? r_fix : q_fix;
              state     <= S_RESP;
`ifdef DIV_RESULT_REUSE_EN
              c_valid   <= 1'b1;
              c_signed  <= signed_l;
              c_rs1     <= rs1_l;
              c_rs2     <= rs2_l;
              c_quot    <= q_fix;
              c_rem     <= r_fix;
`endif
            end
          end else if (kill) begin
            state <= S_DRAIN;
          end
        end
        S_RESP: begin
          if (kill || resp_ready) state <= S_IDLE;
        end
        S_DRAIN: begin
          if (div_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed requests against a behavioural divider,
// with expected responses queued at issue and checked by a separate monitor.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        kill = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        div_start;
  logic        div_ready;
  logic        div_valid = 1'b0;
  logic        div_error = 1'b0;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient = '0;
  logic [31:0] div_remainder = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .div_start(div_start), .div_ready(div_ready), .div_valid(div_valid),
    .div_error(div_error), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // behavioural divider: D=1 when divisor>dividend, else D=33
  logic       dv_busy = 1'b0;
  logic [5:0] dv_cnt = '0;
  assign div_ready = !dv_busy;

  always @(posedge clk) begin
    div_valid <= 1'b0;
    if (!reset_n) begin
      dv_busy <= 1'b0;
      dv_cnt  <= '0;
    end else if (dv_busy) begin
      if (dv_cnt == 6'd1) begin
        dv_busy   <= 1'b0;
        div_valid <= 1'b1;
      end else begin
        dv_cnt <= dv_cnt - 6'd1;
      end
    end else if (div_start) begin
      div_quotient  <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
      div_remainder <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      if (div_divisor > div_dividend) div_valid <= 1'b1;
      else begin
        dv_busy <= 1'b1;
        dv_cnt  <= 6'd32;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every taken response is compared with the oldest queued expectation
  always @(negedge clk) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", resp_data, 32'hDEAD_BEEF ^ resp_data ^ 32'h1);
      else chk("resp_data", resp_data, exp_q.pop_front());
    end
  end

  task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] exp, input int lat,
                        input logic exp_start, input int hold);
    int n;
    int w;
    logic started;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(exp);
    n = 0; started = 1'b0;
    do begin
      @(negedge clk); n++;
      if (div_start) started = 1'b1;
    end while (!resp_valid && n < 100);
    chk({name, "_latency"}, n, lat);
    chk({name, "_start_seen"}, {31'd0, started}, {31'd0, exp_start});
    if (!resp_valid) begin
      void'(exp_q.pop_back());
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({name, "_hold_data"}, resp_data, exp);
      chk({name, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

`ifdef DIV_RESULT_REUSE_EN
  localparam int  REUSE_LAT   = 1;
  localparam logic REUSE_START = 1'b0;
`else
  localparam int  REUSE_LAT   = 35;
  localparam logic REUSE_START = 1'b1;
`endif

  initial begin
    logic saw_resp;
    logic early_ready;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", div_divisor, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
    kill = 1'b1;
    #1;
    chk("idle_kill_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;

    do_req("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b1, 0);
    chk("mag_dividend", div_dividend, 32'd7);
    chk("mag_divisor", div_divisor, 32'd2);
    do_req("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, REUSE_LAT, REUSE_START, 0);
    do_req("divu_by0", 2'b01, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
    do_req("remu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 1, 1'b0, 0);
    do_req("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 0);
    do_req("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);
    do_req("divu_max_3", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 35, 1'b1, 5);
    do_req("divu_short", 2'b01, 32'd3, 32'd10, 32'd0, 3, 1'b1, 0);
    do_req("rem_short", 2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 3, 1'b1, 0);

    // kill while the divider is busy: no response, req_ready held low until it finishes
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'h0000_1234; req_rs2 = 32'd5;
    @(negedge clk);
    chk("kill_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    saw_resp = 1'b0; early_ready = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
      if (req_ready && dv_busy) early_ready = 1'b1;
    end
    chk("kill_no_resp", {31'd0, saw_resp}, 32'd0);
    chk("kill_drain_ready", {31'd0, early_ready}, 32'd0);
    chk("kill_ready_after", {31'd0, req_ready}, 32'd1);

    do_req("divu_10_3", 2'b01, 32'd10, 32'd3, 32'd3, 35, 1'b1, 0);
    do_req("div_50_7", 2'b00, 32'd50, 32'd7, 32'd7, 35, 1'b1, 0);
    do_req("rem_50_7", 2'b10, 32'd50, 32'd7, 32'd1, REUSE_LAT, REUSE_START, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller that sequences the shared unsigned N-bit iterative divider for the RV M-extension DIV/DIVU/REM/REMU instructions. It sits between the execute stage and the divider. It accepts one request at a time and converts signed operands to magnitudes. It resolves divide-by-zero and signed overflow without using the divider, drives the divider's start/ready/valid handshake, and applies sign correction before returning a held result to the pipeline.

## Interface
- XLEN, 32, operand/result width; must equal the divider's SIZE.
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_rs1, req_rs2  in  XLEN  dividend, divisor.
- kill  in  1  pipeline flush; abandons the current operation.
- resp_valid  out  1  result available; held until taken.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU).
- div_start  out  1  divider start pulse.
- div_ready, div_valid, div_error  in  1  divider status; div_valid is a one-cycle pulse.
- div_dividend, div_divisor  out  XLEN  magnitudes sent to the divider.
- div_quotient, div_remainder  in  XLEN  divider results, sampled only while div_valid=1.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready = (state==IDLE) && !kill.
- On accept, the block latches:
  - req_op;
  - is_signed = !req_op[0];
  - neg_q = is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
  - neg_r = is_signed && rs1[XLEN-1];
  - the original rs1;
  - magnitudes |rs1| and |rs2| (taken only when is_signed; two's complement, so |0x8000_0000| = 0x8000_0000 unsigned).
- Fast paths go IDLE→RESP without using the divider:
  - rs2==0: quotient = all-ones, remainder = rs1.
  - Signed, rs1 = 1<<(XLEN-1) and rs2 = all-ones: quotient = rs1, remainder = 0.
- All other requests go IDLE→ISSUE.
- ISSUE:
  - div_start = (state==ISSUE) && div_ready && !kill.
  - When div_start=1, the next state is WAIT. Otherwise the block stays in ISSUE.
  - div_dividend and div_divisor are driven from the latched magnitudes continuously.
- WAIT: on div_valid, capture the results and go to RESP.
  - If div_error=1, apply the divide-by-zero fast-path values; this is defensive only.
  - Otherwise: quotient = neg_q ? -div_quotient : div_quotient; remainder = neg_r ? -div_remainder : div_remainder.
- RESP:
  - resp_valid=1.
  - resp_data selects the quotient when op[1]=0 and the remainder when op[1]=1.
  - When resp_ready=1, go to IDLE.
- Kill handling:
  - ISSUE → IDLE; start is suppressed in the same cycle.
  - WAIT → DRAIN, unless div_valid=1 in the same cycle, in which case go directly to IDLE and discard the result.
  - RESP → IDLE; the response is dropped.
  - IDLE: no request is accepted.
- DRAIN: wait for div_valid, discard the result, go to IDLE. req_ready=0 throughout. kill is ignored.
- A div_valid received outside WAIT and DRAIN is ignored.

## Timing
- Reset: state=IDLE; req_ready=1 (absent kill); resp_valid=0; resp_data=0; div_start=0; div_dividend=0; div_divisor=0.
- A divider that is mid-operation at reset is not aborted. ISSUE waits for div_ready, which covers it.
- Fast path latency: accept at edge N, resp_valid from cycle N+1.
- Divider path latency:
  - Accept at edge N.
  - div_start in cycle N+1, if div_ready.
  - The divider pulses div_valid D cycles after start: D=1 for the divisor>dividend shortcut, D=XLEN+1 for a full divide.
  - resp_valid follows in the cycle after div_valid.
  - Full 32-bit divide: resp_valid at N+35.
- resp_valid and resp_data are stable until resp_ready. No combinational path exists from req_* to resp_*.
- Throughput: one operation in flight. The next accept is possible in the cycle after the response handshake.

## Configuration
- DIV_RESULT_REUSE_EN defined:
  - Keep one entry: {valid, is_signed, rs1, rs2, quotient, remainder}.
  - The entry is written whenever a divider-path result reaches RESP.
  - A request matching is_signed, rs1 and rs2 of a valid entry goes IDLE→RESP with the cached, already sign-corrected value. Latency is 1, the same as a fast path.
  - The entry is cleared by reset. It is not written by killed or fast-path operations.
- DIV_RESULT_REUSE_EN undefined: no cache storage. Every non-fast-path request uses the divider.

## Test plan
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → div_dividend=7, div_divisor=2; resp_data=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU rs1=100, rs2=0 → no div_start; resp_data=0xFFFFFFFF at N+1. REMU with the same operands → 100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → resp_data=0x80000000 at N+1. REM with the same operands → 0.
- DIVU 0xFFFFFFFF/3 with resp_ready held low 5 cycles → resp_valid first at N+35, data 0x55555555 held stable, req_ready=0 until the handshake.
- kill in WAIT → DRAIN until div_valid, no resp_valid. The next DIVU 10/3 returns 3.
- With DIV_RESULT_REUSE_EN: DIV 50/7, then REM 50/7 → the second returns 1 at N+1 with no div_start. Without the macro, the second takes the divider path.
